// File: rtl/reg_dump_ctrl.sv
// reg_dump_ctrl: read-side initiator that dumps the register file.
//
// Purpose: on a start pulse, steps the register-file read address from FIRST_REG
// up to NUM_REGS-1. It captures each combinational read value and presents it as
// one beat on a valid/ready stream.
//
// Optional feature (macro REG_DUMP_CHECKSUM_EN): a running XOR of every dumped
// value is appended as a final beat (out_index=0, out_last=1). In this mode all
// register beats carry out_last=0.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   dump request, sampled in IDLE only
//   busy       out  high from the cycle after an accepted start until DONE exits
//   done       out  one-cycle pulse after the final beat is accepted
//   rf_addr    out  register-file read address (registered)
//   rf_data    in   combinational read data for rf_addr
//   out_valid  out  beat valid
//   out_ready  in   downstream accepts the beat
//   out_data   out  beat payload
//   out_index  out  register index of the beat
//   out_last   out  final beat of the dump
module reg_dump_ctrl #(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned FIRST_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last
);

  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] FirstIdx = ADDR_W'(FIRST_REG);

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StRead, StHold, StCsum, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StRead, StHold, StDone} state_e;
`endif

  state_e              r_state, w_state_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_last, w_last_nxt;
  logic [DATA_W-1:0]   r_data, w_data_nxt;
  logic [ADDR_W-1:0]   r_index, w_index_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic                w_hs;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0]   r_csum, w_csum_nxt;
  // Marks the beat in HOLD as the last register; out_last is reserved for the checksum.
  logic                r_final, w_final_nxt;
`endif

  assign w_hs = r_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_valid_nxt = r_valid;
    w_last_nxt  = r_last;
    w_data_nxt  = r_data;
    w_index_nxt = r_index;
    w_addr_nxt  = r_addr;
`ifdef REG_DUMP_CHECKSUM_EN
    w_csum_nxt  = r_csum;
    w_final_nxt = r_final;
`endif
    case (r_state)
      StIdle: begin
        if (start) begin
          w_addr_nxt  = FirstIdx;
          w_busy_nxt  = 1'b1;
          w_state_nxt = StRead;
`ifdef REG_DUMP_CHECKSUM_EN
          w_csum_nxt  = '0;
`endif
        end
      end
      StRead: begin
        // Snapshot taken here; writes on this same edge are not visible.
        w_data_nxt  = rf_data;
        w_index_nxt = r_addr;
        w_valid_nxt = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
        w_last_nxt  = 1'b0;
        w_final_nxt = (r_addr == LastIdx);
        w_csum_nxt  = r_csum ^ rf_data;
`else
        w_last_nxt  = (r_addr == LastIdx);
`endif
        w_state_nxt = StHold;
      end
      StHold: begin
        if (w_hs) begin
          w_valid_nxt = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
          if (r_final) begin
            w_valid_nxt = 1'b1;
            w_data_nxt  = r_csum;
            w_index_nxt = '0;
            w_last_nxt  = 1'b1;
            w_state_nxt = StCsum;
          end else begin
            w_addr_nxt  = r_addr + 1'b1;
            w_state_nxt = StRead;
          end
`else
          if (r_last) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = StDone;
          end else begin
            w_addr_nxt  = r_addr + 1'b1;
            w_state_nxt = StRead;
          end
`endif
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      StCsum: begin
        if (w_hs) begin
          w_valid_nxt = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = StDone;
        end
      end
`endif
      StDone: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
      r_index <= '0;
      r_addr  <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
      r_csum  <= '0;
      r_final <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
      r_data  <= w_data_nxt;
      r_index <= w_index_nxt;
      r_addr  <= w_addr_nxt;
`ifdef REG_DUMP_CHECKSUM_EN
      r_csum  <= w_csum_nxt;
      r_final <= w_final_nxt;
`endif
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign rf_addr   = r_addr;
  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign out_data  = r_data;
  assign out_index = r_index;

endmodule
